// File: rtl/vga_pkg.sv
// Shared definitions for the VGA capture path.
//   HActiveDef / VActiveDef : default active-area geometry (640x480)
//   WrStrb                  : byte strobe for a 24-bit pixel in a 32-bit word
//   cap_state_e             : capture FSM states
//   pix_entry_t             : one buffered pixel with its coordinates
package vga_pkg;

  localparam int unsigned HActiveDef = 640;
  localparam int unsigned VActiveDef = 480;

  localparam logic [3:0] WrStrb = 4'b0111;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StCapture
  } cap_state_e;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [23:0] rgb;
  } pix_entry_t;

endpackage

// File: rtl/vga_cap_fifo.sv
// Synchronous FIFO of pixel entries.
//   clk, clrn    : clock, asynchronous active-low reset
//   push_i       : write request; accepted when not full, or when full and a pop happens too
//   push_data_i  : entry to write
//   pop_i        : read request; ignored when empty
//   pop_data_o   : head entry, stable until popped
//   full_o       : Depth entries held
//   empty_o      : no entries held
module vga_cap_fifo
  import vga_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       push_i,
  input  pix_entry_t push_data_i,
  input  logic       pop_i,
  output pix_entry_t pop_data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(Depth);

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  pix_entry_t  mem_q [Depth];
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/vga_capture.sv
// Pixel-stream receiver: registers the VGA stream, tags active pixels with {x,y} and writes them
// into the framebuffer through a valid/ready write-master port.
//   clk, clrn          : clock, asynchronous active-low reset
//   cap_en             : capture enable (level)
//   vga_r/g/b, hsync, vsync, valid : pixel stream (syncs active-low)
//   WriteAddrOut/DataOut/Strb/Valid, SlaverWriteReady : write-master port
//   busy               : FSM not idle or writes still pending
//   frame_done         : one-cycle pulse at the vsync fall that ends a captured frame
//   overflow           : sticky, a pixel was dropped on a full buffer
//   drop_cnt           : dropped-pixel count, only when VGA_CAP_DROP_CNT_EN is defined
module vga_capture
  import vga_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h5000_0000,
  parameter int unsigned H_ACTIVE   = HActiveDef,
  parameter int unsigned V_ACTIVE   = VActiveDef,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        cap_en,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        valid,
  output logic [31:0] WriteAddrOut,
  output logic [31:0] WriteDataOut,
  output logic [3:0]  WriteStrb,
  output logic        WriteValid,
  input  logic        SlaverWriteReady,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow
`ifdef VGA_CAP_DROP_CNT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);

  localparam logic [9:0] HMax = 10'(H_ACTIVE);
  localparam logic [8:0] VMax = 9'(V_ACTIVE);

  // Input stage and delayed copies for edge detection
  logic [7:0] r_q, g_q, b_q;
  logic       hsync_q, vsync_q, valid_q;
  logic       vsync_dly_q, valid_dly_q;

  cap_state_e state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       frame_done_q, frame_done_d;
  logic       overflow_q, overflow_d;
`ifdef VGA_CAP_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
`endif

  logic       vsync_fall, valid_fall;
  logic       push, pop, drop;
  logic       fifo_full, fifo_empty;
  pix_entry_t push_entry, head;

  // Line timing comes entirely from valid; hsync is sampled but not needed.
  logic unused_hsync;
  assign unused_hsync = hsync_q;

  assign vsync_fall = vsync_dly_q && !vsync_q;
  assign valid_fall = valid_dly_q && !valid_q;

  assign push  = (state_q == StCapture) && valid_q && (x_q < HMax) && (y_q < VMax);
  assign pop   = WriteValid && SlaverWriteReady;
  assign drop  = push && fifo_full && !pop;

  assign push_entry = '{x: x_q, y: y_q, rgb: {r_q, g_q, b_q}};

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
`ifdef VGA_CAP_DROP_CNT_EN
    drop_cnt_d   = drop_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cap_en) begin
          state_d    = StArm;
          overflow_d = 1'b0;
`ifdef VGA_CAP_DROP_CNT_EN
          drop_cnt_d = '0;
`endif
        end
      end
      StArm: begin
        if (!cap_en) begin
          state_d = StIdle;
        end else if (vsync_fall) begin
          state_d = StCapture;
          x_d     = '0;
          y_d     = '0;
        end
      end
      StCapture: begin
        if (vsync_fall) begin
          frame_done_d = 1'b1;
          x_d          = '0;
          y_d          = '0;
          if (!cap_en) state_d = StIdle;
        end else if (valid_fall) begin
          x_d = '0;
          if (y_q < VMax) y_d = y_q + 9'd1;
        end else if (valid_q && (x_q < HMax)) begin
          // Saturating at H_ACTIVE keeps overlong lines from wrapping back into range.
          x_d = x_q + 10'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
`ifdef VGA_CAP_DROP_CNT_EN
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
`endif
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      valid_q      <= 1'b0;
      vsync_dly_q  <= 1'b0;
      valid_dly_q  <= 1'b0;
      state_q      <= StIdle;
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef VGA_CAP_DROP_CNT_EN
      drop_cnt_q   <= '0;
`endif
    end else begin
      r_q          <= vga_r;
      g_q          <= vga_g;
      b_q          <= vga_b;
      hsync_q      <= hsync;
      vsync_q      <= vsync;
      valid_q      <= valid;
      vsync_dly_q  <= vsync_q;
      valid_dly_q  <= valid_q;
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
`ifdef VGA_CAP_DROP_CNT_EN
      drop_cnt_q   <= drop_cnt_d;
`endif
    end
  end

  vga_cap_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .clrn       (clrn),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .pop_data_o (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Address/data are zeroed when idle so the port reads all-zero out of reset.
  assign WriteValid   = !fifo_empty;
  assign WriteAddrOut = WriteValid ? (BASE_ADDR | {13'b0, head.x, head.y}) : '0;
  assign WriteDataOut = WriteValid ? {8'h00, head.rgb} : '0;
  assign WriteStrb    = WriteValid ? WrStrb : 4'b0000;

  assign busy       = (state_q != StIdle) || !fifo_empty;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
`ifdef VGA_CAP_DROP_CNT_EN
  assign drop_cnt   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture: stimulus tasks queue expected writes, a negedge monitor pops
// and compares every transfer, and checks that a stalled write holds its address and data.
module tb_vga_capture;

  localparam logic [31:0] Base = 32'h5000_0000;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        cap_en = 1'b0;
  logic [7:0]  vga_r = '0, vga_g = '0, vga_b = '0;
  logic        hsync = 1'b1, vsync = 1'b1, valid = 1'b0;
  logic        SlaverWriteReady = 1'b1;
  logic [31:0] WriteAddrOut, WriteDataOut;
  logic [3:0]  WriteStrb;
  logic        WriteValid, busy, frame_done, overflow;
`ifdef VGA_CAP_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  vga_capture dut (
    .clk             (clk),
    .clrn            (clrn),
    .cap_en          (cap_en),
    .vga_r           (vga_r),
    .vga_g           (vga_g),
    .vga_b           (vga_b),
    .hsync           (hsync),
    .vsync           (vsync),
    .valid           (valid),
    .WriteAddrOut    (WriteAddrOut),
    .WriteDataOut    (WriteDataOut),
    .WriteStrb       (WriteStrb),
    .WriteValid      (WriteValid),
    .SlaverWriteReady(SlaverWriteReady),
    .busy            (busy),
    .frame_done      (frame_done),
    .overflow        (overflow)
`ifdef VGA_CAP_DROP_CNT_EN
    ,
    .drop_cnt        (drop_cnt)
`endif
  );

  int          n_checks = 0;
  int          n_pass = 0;
  int          wr_cnt = 0;
  int          frame_cnt = 0;
  logic [63:0] sb [$];
  logic [31:0] seen_addr [$];
  logic [31:0] seen_data [$];
  logic        prev_stall = 1'b0;
  logic [31:0] stall_addr, stall_data;
  logic [63:0] e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compare every transfer against the scoreboard.
  always @(negedge clk) begin
    if (!clrn) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_done) frame_cnt++;
      if (prev_stall) begin
        chk("stall_valid", {31'b0, WriteValid}, 32'd1);
        chk("stall_addr", WriteAddrOut, stall_addr);
        chk("stall_data", WriteDataOut, stall_data);
      end
      if (WriteValid && SlaverWriteReady) begin
        wr_cnt++;
        seen_addr.push_back(WriteAddrOut);
        seen_data.push_back(WriteDataOut);
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: got addr %h data %h expected none",
                   WriteAddrOut, WriteDataOut);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", WriteAddrOut, e[63:32]);
          chk("wr_data", WriteDataOut, e[31:0]);
          chk("wr_strb", {28'b0, WriteStrb}, 32'h7);
        end
        prev_stall = 1'b0;
      end else if (WriteValid) begin
        prev_stall = 1'b1;
        stall_addr = WriteAddrOut;
        stall_data = WriteDataOut;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vsync_pulse();
    valid = 1'b0;
    vsync = 1'b0;
    step();
    step();
    vsync = 1'b1;
    repeat (3) step();
  endtask

  // Sends n pixels on line y; the first nexp of them (and only x < 640) are expected as writes.
  task automatic send_line(input int n, input int nexp, input int y);
    for (int i = 0; i < n; i++) begin
      valid = 1'b1;
      vga_r = 8'(i);
      vga_g = 8'(y);
      vga_b = 8'hC3;
      if (i < nexp && i < 640)
        sb.push_back({Base | {13'b0, 10'(i), 9'(y)}, {8'h00, 8'(i), 8'(y), 8'hC3}});
      step();
    end
    valid = 1'b0;
    hsync = 1'b0;
    step();
    step();
    hsync = 1'b1;
    step();
    step();
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin
      step();
      t++;
    end
    repeat (3) step();
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, WriteAddrOut, 32'd0);
    chk({tag, "_data"}, WriteDataOut, 32'd0);
    chk({tag, "_strb"}, {28'b0, WriteStrb}, 32'd0);
    chk({tag, "_valid"}, {31'b0, WriteValid}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_frame_done"}, {31'b0, frame_done}, 32'd0);
    chk({tag, "_overflow"}, {31'b0, overflow}, 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int w0, f0;
    #2;
    chk_all_zero("reset");
    repeat (3) step();
    clrn = 1'b1;
    step();

    // Small 4x3 frame
    cap_en = 1'b1;
    step();
    step();
    vsync_pulse();
    for (int y = 0; y < 3; y++) send_line(4, 4, y);
    vsync_pulse();
    drain("t2_drain");
    chk("t2_wr_cnt", 32'(wr_cnt), 32'd12);
    chk("t2_first_addr", seen_addr[0], 32'h5000_0000);
    chk("t2_addr_3_2", seen_addr[11], 32'h5000_0602);
    chk("t2_data_3_2", seen_data[11], 32'h0003_02C3);
    chk("t2_frame_done", 32'(frame_cnt), 32'd1);
    chk("t2_overflow", {31'b0, overflow}, 32'd0);

    // Stall for 20 cycles during a 16-pixel line
    w0 = wr_cnt;
    SlaverWriteReady = 1'b0;
    send_line(16, 8, 0);
    chk("t3_overflow", {31'b0, overflow}, 32'd1);
    chk("t3_no_write_stalled", 32'(wr_cnt - w0), 32'd0);
    SlaverWriteReady = 1'b1;
    drain("t3_drain");
    chk("t3_wr_cnt", 32'(wr_cnt - w0), 32'd8);
`ifdef VGA_CAP_DROP_CNT_EN
    chk("t3_drop_cnt", {16'b0, drop_cnt}, 32'd8);
`endif

    // Full FIFO with a push and a pop in the same cycle
    cap_en = 1'b0;
    vsync_pulse();
    chk("t4_frame_done", 32'(frame_cnt), 32'd2);
    cap_en = 1'b1;
    step();
    step();
    chk("t4_overflow_cleared", {31'b0, overflow}, 32'd0);
`ifdef VGA_CAP_DROP_CNT_EN
    chk("t4_drop_cnt_cleared", {16'b0, drop_cnt}, 32'd0);
`endif
    vsync_pulse();
    w0 = wr_cnt;
    SlaverWriteReady = 1'b0;
    for (int i = 0; i < 9; i++) begin
      valid = 1'b1;
      vga_r = 8'(i);
      vga_g = 8'd0;
      vga_b = 8'hC3;
      sb.push_back({Base | {13'b0, 10'(i), 9'd0}, {8'h00, 8'(i), 8'd0, 8'hC3}});
      step();
    end
    // Pixel 8 reaches the full FIFO on the next edge, together with the first pop.
    valid = 1'b0;
    SlaverWriteReady = 1'b1;
    repeat (3) step();
    drain("t4_drain");
    chk("t4_wr_cnt", 32'(wr_cnt - w0), 32'd9);
    chk("t4_overflow", {31'b0, overflow}, 32'd0);
`ifdef VGA_CAP_DROP_CNT_EN
    chk("t4_drop_cnt", {16'b0, drop_cnt}, 32'd0);
`endif

    // cap_en dropped mid-frame
    w0 = wr_cnt;
    f0 = frame_cnt;
    send_line(4, 4, 1);
    cap_en = 1'b0;
    send_line(4, 4, 2);
    vsync_pulse();
    send_line(4, 0, 0);
    vsync_pulse();
    drain("t5_drain");
    chk("t5_wr_cnt", 32'(wr_cnt - w0), 32'd8);
    chk("t5_frame_done", 32'(frame_cnt - f0), 32'd1);
    chk("t5_busy", {31'b0, busy}, 32'd0);

    // Overlong line
    w0 = wr_cnt;
    cap_en = 1'b1;
    step();
    step();
    vsync_pulse();
    send_line(700, 700, 0);
    send_line(2, 2, 1);
    cap_en = 1'b0;
    vsync_pulse();
    drain("t6_drain");
    chk("t6_wr_cnt", 32'(wr_cnt - w0), 32'd642);
    chk("t6_addr_639", seen_addr[w0 + 639], 32'h5004_FE00);
    chk("t6_addr_0_1", seen_addr[w0 + 640], 32'h5000_0001);

    // Asynchronous reset in the middle of a capture with a pending write
    cap_en = 1'b1;
    step();
    step();
    vsync_pulse();
    SlaverWriteReady = 1'b0;
    send_line(4, 0, 0);
    chk("t1_valid_pending", {31'b0, WriteValid}, 32'd1);
    @(posedge clk);
    #3;
    clrn = 1'b0;
    #1;
    chk_all_zero("t1_async");
    sb.delete();
    cap_en = 1'b0;
    SlaverWriteReady = 1'b1;
    step();
    step();
    clrn = 1'b1;
    step();
    step();
    chk("t1_busy", {31'b0, busy}, 32'd0);
    chk("t1_valid", {31'b0, WriteValid}, 32'd0);
    w0 = wr_cnt;
    vsync_pulse();
    send_line(3, 0, 0);
    repeat (5) step();
    chk("t1_idle_no_writes", 32'(wr_cnt - w0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
